// File: rtl/dff_pkg.sv
// Shared constants for the Hack storage primitive and the blocks built on it.
package dff_pkg;

    localparam int DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/dff.sv
// Edge-triggered D flip-flop with asynchronous active-high reset.
// Every bit is an independent storage cell; there is no path from in to out except through the flop.
module dff
    import dff_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    always_comb begin
        out_d = in;
    end

    // Reset has priority over a coincident rising clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: directed Hack test plan followed by randomized cycles against a reference model.
module tb_dff;

    localparam logic [7:0] BYTE_RESET = 8'hA5;

    logic       clk;
    logic       rst;
    logic       in_a;
    logic       out_a;
    logic [7:0] in_b;
    logic [7:0] out_b;

    int compared   = 0;
    int mismatched = 0;

    logic       model_a;
    logic [7:0] model_b;

    dff u_bit (
        .clk (clk),
        .rst (rst),
        .in  (in_a),
        .out (out_a)
    );

    dff #(
        .WIDTH       (8),
        .RESET_VALUE (BYTE_RESET)
    ) u_byte (
        .clk (clk),
        .rst (rst),
        .in  (in_b),
        .out (out_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic [7:0] b);
        rst  = r;
        in_a = a;
        in_b = b;
    endtask

    initial begin
        logic r;
        clk = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h00);
        #5;

        // Directed sequence from the Hack test plan.
        rst = 1'b1;
        #1;
        checkOutput("rst_async_bit", {7'b0, out_a}, 8'h00);
        checkOutput("rst_async_byte", out_b, BYTE_RESET);
        #4 clk = 1'b1;
        #1;
        checkOutput("rst_hold_edge", {7'b0, out_a}, 8'h00);
        #4 clk = 1'b0;
        #5 applyStimulus(1'b0, 1'b0, 8'h3C);
        #5 clk = 1'b1;
        #1;
        checkOutput("capture0", {7'b0, out_a}, 8'h00);
        checkOutput("release_byte", out_b, 8'h3C);
        #4 clk = 1'b0; in_a = 1'b1;
        #1;
        checkOutput("hold_low", {7'b0, out_a}, 8'h00);
        #4 clk = 1'b1;
        #1;
        checkOutput("capture1", {7'b0, out_a}, 8'h01);
        #4 clk = 1'b0; in_a = 1'b0;
        #1;
        checkOutput("hold_falling", {7'b0, out_a}, 8'h01);
        #4 clk = 1'b1;
        #1;
        checkOutput("capture_after_hold", {7'b0, out_a}, 8'h00);
        #4 clk = 1'b0;
        #5;
        // The data update lands in the NBA region, after the edge has already sampled in.
        in_a <= 1'b1;
        clk = 1'b1;
        #1;
        checkOutput("race_old_in", {7'b0, out_a}, 8'h00);
        #4 clk = 1'b0;
        #5 clk = 1'b1;
        #1;
        checkOutput("race_next_edge", {7'b0, out_a}, 8'h01);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_bit", {7'b0, out_a}, 8'h00);
        checkOutput("rst_mid_byte", out_b, BYTE_RESET);
        #2 clk = 1'b0;
        #5 rst = 1'b0;
        #5;

        // Randomized phase: model is "reset forces the reset value, otherwise each rising edge copies in".
        model_a = 1'b0;
        model_b = BYTE_RESET;
        for (int cyc = 0; cyc < 300; cyc++) begin
            r = ($urandom_range(0, 7) == 0);
            applyStimulus(r, 1'($urandom), 8'($urandom));
            if (r) begin
                model_a = 1'b0;
                model_b = BYTE_RESET;
            end
            #1;
            checkOutput("rnd_low_bit", {7'b0, out_a}, {7'b0, model_a});
            checkOutput("rnd_low_byte", out_b, model_b);
            #4 clk = 1'b1;
            if (!rst) begin
                model_a = in_a;
                model_b = in_b;
            end
            #1;
            checkOutput("rnd_edge_bit", {7'b0, out_a}, {7'b0, model_a});
            checkOutput("rnd_edge_byte", out_b, model_b);
            in_a = ~in_a;
            in_b = 8'($urandom);
            #1;
            checkOutput("rnd_high_byte", out_b, model_b);
            #3 clk = 1'b0;
            #1;
            checkOutput("rnd_fall_bit", {7'b0, out_a}, {7'b0, model_a});
            #3;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
